mux_4x_rr_arbiter: RTL and testbench
====================================

// Module: mux_4x_rr_arbiter
// PURPOSE
//   Shares one BUS_WIDTH-bit output channel among 4 requesters (a..d) using round-robin arbitration.
//   Drives the select of a mux_4x_nbit datapath and captures the winner into a one-deep output register.
//   The output register uses a valid/ready handshake downstream. Requesters hold data until acknowledged.
//   Sits between 4 producer blocks and a single consumer (e.g. shared bus or UART TX).
// PARAMETERS
//   BUS_WIDTH  8  width of each data input and of y
// PORTS
//   clk        in   1          single clock; all state on posedge
//   reset      in   1          asynchronous, active-high reset
//   req        in   4          req[i]=1: requester i holds valid data on its bus (0=a,1=b,2=c,3=d)
//   a,b,c,d    in   BUS_WIDTH  requester data; must be stable while req[i]=1
//   req_ack    out  4          one-hot, 1-cycle pulse: data of requester i captured this edge
//   y          out  BUS_WIDTH  registered output data
//   y_valid    out  1          y holds an unconsumed word
//   y_ready    in   1          consumer accepts y when y_valid & y_ready
//   sel        out  2          index of requester whose data is in y
//   lock       in   4          [ARB_LOCK_EN only] lock[i]=1 keeps grant on i after capture
// BEHAVIOUR
//   - Reset (async, any time, incl. mid-transfer): y=0, y_valid=0, sel=0, req_ack=0, rr pointer last=3,
//     lock_owner cleared; an in-flight word is dropped.
//   - accept = |req_eligible & (!y_valid | y_ready). Back-to-back allowed: drain and capture on the same edge.
//   - Winner: first set bit of req in order last+1, last+2, last+3, last (mod 4 wrap-around).
//   - On accept edge: y<=winner data, sel<=winner, y_valid<=1, last<=winner, req_ack<=onehot(winner), 1 cycle.
//   - Latency: req seen in cycle N (channel free) -> y_valid and req_ack high after edge N+1; one word per cycle max.
//   - y_valid & y_ready & no accept -> y_valid<=0; y and sel hold their last value.
//   - y_valid & !y_ready -> y and sel held; no new capture; all req wait (backpressure).
//   - Requester i must drop req[i] or present new data in the cycle req_ack[i]=1;
//     req still high then counts as a new request.
//   - Simultaneous requests: exactly one ack per accept; the same requester never wins twice while
//     another requester is waiting (no lock).
//   - Control FSM: EMPTY (y_valid=0) / FULL (y_valid=1). EMPTY->FULL on accept; FULL->EMPTY on drain
//     with no accept; FULL->FULL on drain+accept or stall.
// CONFIGURATION
//   ARB_LOCK_EN defined: lock port present. Winner i with lock[i]=1 becomes lock_owner; only req[lock_owner]
//     is eligible while lock[lock_owner]=1. lock[lock_owner]=0 -> release, normal RR resumes from last.
//   ARB_LOCK_EN undefined: no lock port, no lock_owner register; pure round-robin.
// STRUCTURE
//   Package mux_arb_pkg: N_REQ=4, typedef logic [1:0] req_idx_t, typedef enum {EMPTY,FULL} arb_state_t.
//   Sub-modules:
//     rr_pick4: combinational pick of the next winner from req, last and the lock mask.
//     mux_4x_nbit #(BUS_WIDTH): data select, driven by the winner index.
// TESTING
//   1. Reset, req=4'b0001, a=8'h11, y_ready=1 -> next edge: y=8'h11, sel=0, y_valid=1, req_ack=4'b0001.
//   2. req=4'b1111 held, y_ready=1 -> sel sequence 0,1,2,3,0 on consecutive cycles, one ack per cycle.
//   3. y_valid=1, y_ready=0 for 5 cycles, req=4'b0100 -> y/sel stable, req_ack=0;
//      y_ready=1 -> c captured same edge as drain.
//   4. last=3, req=4'b1001 -> winner 0; next accept, req=4'b1001 -> winner 3 (wrap-around).
//   5. Assert reset while y_valid=1 -> y_valid=0, y=0, sel=0 immediately (no clock);
//      after release req=4'b1000 -> winner 3.
//   6. ARB_LOCK_EN: lock=4'b0010, req=4'b0110 -> b wins 3 times in a row; lock=0 -> next winner 2.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types for the 4-way round-robin output arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] req_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx_onehot(input req_idx_t idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_4x_nbit.sv
// Plain 4:1 data select of BUS_WIDTH-bit buses.
module mux_4x_nbit
  import mux_arb_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [BUS_WIDTH-1:0] c,
  input  logic [BUS_WIDTH-1:0] d,
  input  req_idx_t             sel,
  output logic [BUS_WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (sel)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first eligible requester after last, wrapping back to last.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  req_idx_t         last,
  output logic             any,
  output req_idx_t         winner
);

  logic [N_REQ-1:0] elig;
  req_idx_t         idx;

  assign elig = req & mask;

  always_comb begin
    any    = 1'b0;
    winner = last;
    idx    = last;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + req_idx_t'(k);
      if (!any && elig[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mux_4x_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready channel among 4 requesters.
// Optional grant locking is built when ARB_LOCK_EN is defined.
//   state | meaning
//   EMPTY | output register holds no unconsumed word
//   FULL  | y holds a word waiting for y_ready
module mux_4x_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [BUS_WIDTH-1:0] c,
  input  logic [BUS_WIDTH-1:0] d,
  output logic [N_REQ-1:0]     req_ack,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output req_idx_t             sel
`ifdef ARB_LOCK_EN
  ,
  input  logic [N_REQ-1:0]     lock
`endif
);

  arb_state_t           state, state_next;
  req_idx_t             last, winner;
  logic                 any_elig, accept;
  logic [N_REQ-1:0]     mask;
  logic [BUS_WIDTH-1:0] mux_y;

`ifdef ARB_LOCK_EN
  logic     lock_active;
  req_idx_t lock_owner;
  logic     lock_hold;

  assign lock_hold = lock_active & lock[lock_owner];
  assign mask      = lock_hold ? idx_onehot(lock_owner) : '1;

  // Dropping lock[owner] releases immediately; RR resumes from last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_owner  <= '0;
    end else if (accept && lock[winner]) begin
      lock_active <= 1'b1;
      lock_owner  <= winner;
    end else if (!lock_hold) begin
      lock_active <= 1'b0;
    end
  end
`else
  assign mask = '1;
`endif

  rr_pick4 u_pick (
    .req    (req),
    .mask   (mask),
    .last   (last),
    .any    (any_elig),
    .winner (winner)
  );

  mux_4x_nbit #(.BUS_WIDTH(BUS_WIDTH)) u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (winner),
    .y   (mux_y)
  );

  assign y_valid = (state == FULL);
  assign accept  = any_elig & ((state == EMPTY) | y_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (!accept && y_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y       <= '0;
      sel     <= '0;
      last    <= 2'd3;
      req_ack <= '0;
    end else begin
      req_ack <= '0;
      if (accept) begin
        y       <= mux_y;
        sel     <= winner;
        last    <= winner;
        req_ack <= idx_onehot(winner);
      end
    end
  end

endmodule

// File: tb/tb_mux_4x_rr_arbiter.sv
// Scoreboard bench for mux_4x_rr_arbiter: directed scenarios then randomized traffic.
module tb_mux_4x_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0;
  logic [7:0] dat [4];
  logic       y_ready = 1'b0;
  logic [3:0] req_ack;
  logic [7:0] y;
  logic       y_valid;
  logic [1:0] sel;
`ifdef ARB_LOCK_EN
  logic [3:0] lock = 4'b0;
`endif

  always #5 clk = ~clk;

  mux_4x_rr_arbiter #(.BUS_WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .a       (dat[0]),
    .b       (dat[1]),
    .c       (dat[2]),
    .d       (dat[3]),
    .req_ack (req_ack),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .sel     (sel)
`ifdef ARB_LOCK_EN
    ,
    .lock    (lock)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
    logic [3:0] ack;
  } cap_t;

  cap_t exp_q [$];
  int   total = 0;
  int   bad = 0;

  // Reference model state: values the DUT should show after the coming edge.
  int         m_last = 3;
  bit         m_valid = 1'b0;
  logic [7:0] m_y = 8'h00;
  int         m_sel = 0;
  logic [3:0] m_ack = 4'b0;
  int         m_owner = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rdy);
    logic [3:0] elig;
    int w;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (r[i] && (!req[i] || m_ack[i])) dat[i] = 8'($urandom);
    req = r;
    y_ready = rdy;
    elig = r;
`ifdef ARB_LOCK_EN
    if (m_owner >= 0 && !lock[m_owner]) m_owner = -1;
    if (m_owner >= 0) elig = r & (4'b0001 << m_owner);
`endif
    if (elig != 4'b0 && (!m_valid || rdy)) begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && elig[(m_last + k) % 4]) w = (m_last + k) % 4;
      m_y = dat[w];
      m_sel = w;
      m_valid = 1'b1;
      m_last = w;
      m_ack = 4'b0001 << w;
      exp_q.push_back('{dat[w], 2'(w), m_ack});
`ifdef ARB_LOCK_EN
      if (lock[w]) m_owner = w;
`endif
    end else begin
      m_ack = 4'b0;
      if (m_valid && rdy) m_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    reset = 1'b1;
    req = 4'b0;
    m_last = 3; m_valid = 1'b0; m_y = 8'h00; m_sel = 0; m_ack = 4'b0; m_owner = -1;
    exp_q.delete();
    #1;
    if (check) begin
      chk("rst_async_valid", y_valid, 0);
      chk("rst_async_y", y, 0);
      chk("rst_async_sel", sel, 0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic post_chk(input string name, input logic [31:0] exp);
    @(posedge clk);
    #2;
    chk(name, sel, exp);
  endtask

  initial begin
    cap_t c;
    forever begin
      @(posedge clk);
      #1;
      chk("y_valid", y_valid, m_valid);
      chk("req_ack", req_ack, m_ack);
      if (req_ack != 4'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_capture", req_ack, 0);
        end else begin
          c = exp_q.pop_front();
          chk("cap_y", y, c.d);
          chk("cap_sel", sel, c.s);
          chk("cap_ack", req_ack, c.ack);
        end
      end else begin
        chk("hold_y", y, m_y);
        chk("hold_sel", sel, m_sel);
      end
    end
  end

  initial begin
    logic [1:0] seq2 [5];
    seq2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;

    do_reset(1'b0);
    step(4'b0001, 1'b1);
    @(posedge clk); #2;
    chk("t1_sel", sel, 0);
    chk("t1_y", y, dat[0]);
    chk("t1_ack", req_ack, 4'b0001);
    step(4'b0000, 1'b1);

    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1);
      post_chk("t2_sel", 32'(seq2[i]));
    end
    step(4'b0000, 1'b1);

    step(4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0100, 1'b0);
      @(posedge clk); #2;
      chk("t3_stall_ack", req_ack, 4'b0);
      chk("t3_stall_sel", sel, 0);
    end
    step(4'b0100, 1'b1);
    post_chk("t3_drain_capture_sel", 2);
    chk("t3_valid", y_valid, 1);

    do_reset(1'b0);
    step(4'b1001, 1'b1);
    post_chk("t4_first", 0);
    step(4'b1001, 1'b1);
    post_chk("t4_wrap", 3);

    step(4'b0000, 1'b0);
    do_reset(1'b1);
    step(4'b1000, 1'b1);
    post_chk("t5_after_reset", 3);
    step(4'b0000, 1'b1);

`ifdef ARB_LOCK_EN
    do_reset(1'b0);
    lock = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step(4'b0110, 1'b1);
      post_chk("t6_locked", 1);
    end
    lock = 4'b0000;
    step(4'b0110, 1'b1);
    post_chk("t6_release", 2);
    step(4'b0000, 1'b1);
`endif

    for (int n = 0; n < 800; n++) begin
      if (n == 400) do_reset(1'b0);
`ifdef ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) lock = 4'($urandom);
`endif
      step((req & ~m_ack) | 4'($urandom & $urandom), ($urandom_range(0, 3) != 0));
    end
`ifdef ARB_LOCK_EN
    lock = 4'b0000;
`endif
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    @(posedge clk); #2;
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
